// File: rtl/sreg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// sreg_pkg : shared state encoding and default width for sreg_pipo_ctrl
// Rev 1.0
// ---------------------------------------------------------------------
package sreg_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sreg_bitcnt.sv
`default_nettype none
// ---------------------------------------------------------------------
// sreg_bitcnt : modulo-WIDTH shift counter with clear/enable and terminal count
// Rev 1.0
// ---------------------------------------------------------------------
module sreg_bitcnt
  import sreg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Wrap on the final shift so the count never exceeds WIDTH-1.
      cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sreg_pipo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------
// sreg_pipo_ctrl : load/shift register with start/busy/done handshake
// Rev 1.0
// ---------------------------------------------------------------------
module sreg_pipo_ctrl
  import sreg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic             move_o,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  sreg_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          q_d     = data_i;
          cnt_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        q_d    = {q_q[WIDTH-2:0], serial_i};
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  // All outputs are decoded from registered state only.
  assign serial_o = (state_q == SHIFT) ? q_q[WIDTH-1] : 1'b0;
  assign move_o   = (state_q != SHIFT);
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign q_o      = q_q;

endmodule
`default_nettype wire

// File: tb/tb_sreg_pipo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_sreg_pipo_ctrl : directed scoreboard bench for sreg_pipo_ctrl (WIDTH=8)
// Rev 1.0
// ---------------------------------------------------------------------
module tb_sreg_pipo_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] data_i;
  logic       serial_i;
  logic       serial_o;
  logic       move_o;
  logic [7:0] q_o;
  logic       busy_o;
  logic       done_o;

  int n_total  = 0;
  int n_passed = 0;

  logic       tx_q[$];
  logic [7:0] rx_q[$];

  sreg_pipo_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .data_i   (data_i),
    .serial_i (serial_i),
    .serial_o (serial_o),
    .move_o   (move_o),
    .q_o      (q_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_q"},      32'(q_o),      32'h00);
    check({tag, "_serial"}, 32'(serial_o), 32'd0);
    check({tag, "_move"},   32'(move_o),   32'd1);
    check({tag, "_busy"},   32'(busy_o),   32'd0);
    check({tag, "_done"},   32'(done_o),   32'd0);
  endtask

  // One full transfer starting from IDLE; called with inputs settled after an edge.
  task automatic run_xfer(input logic [7:0] d, input logic [7:0] rx,
                          input bit loopback, input bit hold_start);
    int   busy_cnt;
    logic exp_bit;
    busy_cnt = 0;
    start_i  = 1'b1;
    data_i   = d;
    for (int i = 0; i < 8; i++) tx_q.push_back(d[7-i]);
    rx_q.push_back(loopback ? d : rx);
    tick();
    if (!hold_start) start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) check("load_q", 32'(q_o), 32'(d));
      check("shift_busy", 32'(busy_o), 32'd1);
      check("shift_move", 32'(move_o), 32'd0);
      check("shift_done", 32'(done_o), 32'd0);
      if (tx_q.size() == 0) begin
        check("tx_underflow", 32'(tx_q.size()), 32'd1);
      end else begin
        exp_bit = tx_q.pop_front();
        check("serial_o", 32'(serial_o), 32'(exp_bit));
      end
      busy_cnt += int'(busy_o);
      serial_i = loopback ? serial_o : rx[7-i];
      data_i   = 8'($urandom);
      tick();
    end
    check("done_pulse", 32'(done_o), 32'd1);
    check("done_move",  32'(move_o), 32'd1);
    check("done_serial", 32'(serial_o), 32'd0);
    if (rx_q.size() == 0) check("rx_underflow", 32'(rx_q.size()), 32'd1);
    else check("done_q", 32'(q_o), 32'(rx_q.pop_front()));
    busy_cnt += int'(busy_o);
    tick();
    check("idle_done", 32'(done_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_move", 32'(move_o), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'd9);
  endtask

  initial begin
    rst_i    = 1'b1;
    start_i  = 1'b0;
    data_i   = 8'h00;
    serial_i = 1'b0;
    #12;
    check_reset_values("in_reset");
    tick();
    rst_i = 1'b0;

    // Idle hold: no start, outputs stay at reset values.
    for (int i = 0; i < 20; i++) begin
      check("idle_hold_move", 32'(move_o), 32'd1);
      check("idle_hold_q",    32'(q_o),    32'h00);
      tick();
    end
    check_reset_values("after_idle");

    // Transmit only.
    run_xfer(8'hA5, 8'h00, 1'b0, 1'b0);
    // Loopback.
    run_xfer(8'h3C, 8'h00, 1'b1, 1'b0);
    // Receive.
    run_xfer(8'h00, 8'hCA, 1'b0, 1'b0);

    // Start held high: back-to-back transfers accepted every 10 edges.
    run_xfer(8'h96, 8'h5B, 1'b0, 1'b1);
    check("held_start_idle_busy", 32'(busy_o), 32'd0);
    run_xfer(8'h71, 8'hE4, 1'b0, 1'b1);
    start_i = 1'b0;
    tick();
    check("after_held_busy", 32'(busy_o), 32'd0);

    // Asynchronous reset partway through a shift.
    start_i = 1'b1;
    data_i  = 8'hF0;
    tick();
    start_i = 1'b0;
    check("abort_serial_first", 32'(serial_o), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("abort_pre_busy", 32'(busy_o), 32'd1);
    #3;
    rst_i = 1'b1;
    #1;
    check_reset_values("async_rst");
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check("post_abort_done", 32'(done_o), 32'd0);
      check("post_abort_busy", 32'(busy_o), 32'd0);
      tick();
    end
    run_xfer(8'h5A, 8'h81, 1'b0, 1'b0);

    check("sb_tx_empty", 32'(tx_q.size()), 32'd0);
    check("sb_rx_empty", 32'(rx_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sreg_pipo_ctrl.md
# sreg_pipo_ctrl

Parameterised WIDTH-bit shift register with its control FSM: it loads a parallel word, then shifts it out MSB-first while shifting a serial input in at the LSB. It drives the per-bit select line (`move_o`) of the serial/parallel bit-cell stage downstream, and it provides a start/busy/done handshake to the upstream controller. Single clock domain. Full-duplex serial exchange: every shift both transmits and receives one bit.

## Interface
- `WIDTH`, default 8: register width in bits; legal range ≥ 2.
- `clk_i`  in  1: clock; all state updates on rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high; forces IDLE and clears all registers.
- `start_i`  in  1: start request; sampled only in IDLE.
- `data_i`  in  WIDTH: parallel load word, captured on the accepting edge.
- `serial_i`  in  1: serial input bit, shifted into the LSB on each SHIFT edge.
- `serial_o`  out  1: serial output bit = current register MSB while in SHIFT, else 0.
- `move_o`  out  1: bit-cell select; 1 = parallel path (IDLE, DONE), 0 = serial path (SHIFT).
- `q_o`  out  WIDTH: register contents; this is the received word when DONE is reached.
- `busy_o`  out  1: high whenever the state is not IDLE.
- `done_o`  out  1: single-cycle pulse while in DONE.

## Operation
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE: `start_i=1` at an edge → `q<=data_i`, `cnt<=0`, next state SHIFT. `start_i=0` → stay in IDLE, `q` holds.
- SHIFT: each edge → `q<={q[WIDTH-2:0], serial_i}`, `cnt<=cnt+1`. When `cnt==WIDTH-1` at an edge, that edge performs the final shift and the next state is DONE.
- DONE: one cycle only. `done_o=1` and `q_o` holds the received word. Next edge → IDLE.
- `start_i` is ignored in SHIFT and DONE; requests are not queued.
- `cnt` width is $clog2(WIDTH), unsigned. `cnt` never exceeds WIDTH-1.
- `serial_o`, `move_o`, `busy_o`, and `done_o` are decoded from registered state and `q` (Moore). There is no combinational path from any input to any output.
- Reset mid-operation: the transfer is aborted immediately. After `rst_i` deasserts, the block waits in IDLE for a new `start_i`.

## Timing
- Reset values: state=IDLE, `q_o=0`, `cnt=0`, `serial_o=0`, `move_o=1`, `busy_o=0`, `done_o=0`.
- `start_i` accepted at edge k. SHIFT occupies cycles k+1 … k+WIDTH, and `serial_o` presents bits `data_i[WIDTH-1]` … `data_i[0]` in order.
- `serial_i` is sampled at edges k+1 … k+WIDTH; the first sample lands at the MSB of the final word.
- DONE occupies the cycle after edge k+WIDTH. IDLE returns after edge k+WIDTH+1.
- Earliest next accept is edge k+WIDTH+2. Transfer period is WIDTH+2 cycles.
- `busy_o` rises the cycle after edge k and falls the cycle after edge k+WIDTH+1.

## Structure
- Shared package `sreg_pkg` holds the state typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
- One natural sub-module: `sreg_bitcnt`, the modulo-WIDTH shift counter. Its interface is clear/enable in, terminal-count out.
- The data register and FSM stay in the top module.

## Test plan
- Reset then idle: `rst_i` pulse, `start_i=0` → all outputs equal their reset values; `move_o=1` and `q_o=0` held for 20 cycles.
- Transmit only: WIDTH=8, `data_i=8'hA5`, `serial_i=0` → `serial_o` = 1,0,1,0,0,1,0,1 over cycles k+1…k+8; `q_o=8'h00` and `done_o=1` at cycle k+9 only.
- Loopback: `serial_i` tied to `serial_o`, `data_i=8'h3C` → `q_o=8'h3C` in DONE; `busy_o` high for exactly 9 cycles.
- Receive: `data_i=8'h00`, `serial_i` driven 1,1,0,0,1,0,1,0 → `q_o=8'hCA` in DONE.
- Ignored start: `start_i` held high continuously → accepts at k and k+10 only; `data_i` changes during SHIFT do not affect `q_o`.
- Async reset mid-shift: `rst_i` asserted asynchronously at cycle k+4 → outputs return to reset values without waiting for a clock edge; no `done_o` pulse; the next `start_i` runs a full 8-bit transfer.
